// File: rtl/matmul_pkg.sv
// Shared types and helpers for the matrix-multiply sequencer.
//   state_t : sequencer FSM states
//   idx_w   : index width for a dimension of size n, at least one bit
package matmul_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        WRITE,
        DONE
    } state_t;

    function automatic int unsigned idx_w(input int unsigned n);
        return (n > 32'd1) ? 32'($clog2(n)) : 32'd1;
    endfunction

endpackage

// File: rtl/matmul_mac.sv
// Signed multiply-accumulate at full precision.
//   clock, reset : rising-edge clock, async active-high reset
//   ena          : advance enable; low holds the accumulator
//   clear        : start a new dot product (acc restarts from zero)
//   acc_en       : add a*b this cycle
//   a, b         : signed operands
//   res          : low WIDTH_BIT bits of the accumulator (wraps)
module matmul_mac #(
    parameter int unsigned WIDTH_BIT = 32,
    parameter int unsigned ACC_WIDTH = 2 * WIDTH_BIT + 1
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        ena,
    input  logic                        clear,
    input  logic                        acc_en,
    input  logic signed [WIDTH_BIT-1:0] a,
    input  logic signed [WIDTH_BIT-1:0] b,
    output logic signed [WIDTH_BIT-1:0] res
);

    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [ACC_WIDTH-1:0] a_ext;
    logic signed [ACC_WIDTH-1:0] b_ext;
    logic signed [ACC_WIDTH-1:0] acc_nxt;

    // Sign-extend before multiplying so the product is exact.
    always_comb begin
        a_ext   = ACC_WIDTH'(a);
        b_ext   = ACC_WIDTH'(b);
        acc_nxt = (clear ? '0 : acc) + (acc_en ? a_ext * b_ext : '0);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (ena) begin
            acc <= acc_nxt;
        end
    end

    assign res = WIDTH_BIT'(acc);

endmodule

// File: rtl/matmul_sequencer.sv
// Computes O = A x B one element at a time, reading A/B buffers with
// one-cycle read latency and writing each result over valid/ready.
//   clock, reset            : rising-edge clock, async active-high reset
//   ena                     : global advance enable
//   start / busy / done     : command interface
//   a_rd_en, a_row, a_col   : A read request (i,k); a_rd_data next cycle
//   b_rd_en, b_row, b_col   : B read request (k,j); b_rd_data next cycle
//   o_wr_en, o_row, o_col,
//   o_wr_data, o_ready      : result write handshake
module matmul_sequencer
    import matmul_pkg::*;
#(
    parameter  int unsigned AROWS     = 3,
    parameter  int unsigned ACOLUMNS  = 3,
    parameter  int unsigned BCOLUMNS  = 3,
    parameter  int unsigned WIDTH_BIT = 32,
    parameter  int unsigned ACC_WIDTH = 2 * WIDTH_BIT + 32'($clog2(ACOLUMNS)) + 1,
    localparam int unsigned RW        = idx_w(AROWS),
    localparam int unsigned KW        = idx_w(ACOLUMNS),
    localparam int unsigned CW        = idx_w(BCOLUMNS)
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        ena,
    input  logic                        start,
    output logic                        busy,
    output logic                        done,
    output logic                        a_rd_en,
    output logic [RW-1:0]               a_row,
    output logic [KW-1:0]               a_col,
    input  logic signed [WIDTH_BIT-1:0] a_rd_data,
    output logic                        b_rd_en,
    output logic [KW-1:0]               b_row,
    output logic [CW-1:0]               b_col,
    input  logic signed [WIDTH_BIT-1:0] b_rd_data,
    output logic                        o_wr_en,
    output logic [RW-1:0]               o_row,
    output logic [CW-1:0]               o_col,
    output logic signed [WIDTH_BIT-1:0] o_wr_data,
    input  logic                        o_ready
);

    state_t        state, state_nxt;
    logic [RW-1:0] i_q, i_nxt;
    logic [KW-1:0] k_q, k_nxt;
    logic [CW-1:0] j_q, j_nxt;
    logic          rd_q, rd_nxt;
    logic          wr_q, wr_nxt;
    logic          busy_q, busy_nxt;
    logic          done_q, done_nxt;
    logic          rd_pend_q;
    logic          xfer;
    logic          mac_clear;

    assign xfer      = wr_q & o_ready & ena;
    assign mac_clear = (state == RUN) && (k_q == '0);

    // Next state and counters; everything holds while ena is low.
    always_comb begin
        state_nxt = state;
        i_nxt     = i_q;
        j_nxt     = j_q;
        k_nxt     = k_q;
        if (ena) begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state_nxt = RUN;
                        i_nxt     = '0;
                        j_nxt     = '0;
                        k_nxt     = '0;
                    end
                end
                RUN: begin
                    if (k_q == KW'(ACOLUMNS - 1)) begin
                        state_nxt = DRAIN;
                        k_nxt     = '0;
                    end else begin
                        k_nxt = k_q + KW'(1);
                    end
                end
                DRAIN: state_nxt = WRITE;
                WRITE: begin
                    if (xfer) begin
                        k_nxt = '0;
                        if (j_q == CW'(BCOLUMNS - 1)) begin
                            j_nxt = '0;
                            if (i_q == RW'(AROWS - 1)) begin
                                i_nxt     = '0;
                                state_nxt = DONE;
                            end else begin
                                i_nxt     = i_q + RW'(1);
                                state_nxt = RUN;
                            end
                        end else begin
                            j_nxt     = j_q + CW'(1);
                            state_nxt = RUN;
                        end
                    end
                end
                DONE:    state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
        rd_nxt   = (state_nxt == RUN);
        wr_nxt   = (state_nxt == WRITE);
        busy_nxt = (state_nxt != IDLE);
        done_nxt = (state_nxt == DONE);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            i_q       <= '0;
            j_q       <= '0;
            k_q       <= '0;
            rd_q      <= 1'b0;
            wr_q      <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            rd_pend_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            i_q    <= i_nxt;
            j_q    <= j_nxt;
            k_q    <= k_nxt;
            rd_q   <= rd_nxt;
            wr_q   <= wr_nxt;
            busy_q <= busy_nxt;
            done_q <= done_nxt;
            // Data for a read lands one advancing cycle later, even across stalls.
            if (ena) begin
                rd_pend_q <= rd_q;
            end
        end
    end

    matmul_mac #(
        .WIDTH_BIT (WIDTH_BIT),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_mac (
        .clock  (clock),
        .reset  (reset),
        .ena    (ena),
        .clear  (mac_clear),
        .acc_en (rd_pend_q),
        .a      (a_rd_data),
        .b      (b_rd_data),
        .res    (o_wr_data)
    );

    // Strobes are suppressed in the same cycle ena drops.
    assign a_rd_en = rd_q & ena;
    assign b_rd_en = rd_q & ena;
    assign done    = done_q & ena;
    assign busy    = busy_q;
    assign o_wr_en = wr_q;
    assign a_row   = i_q;
    assign a_col   = k_q;
    assign b_row   = k_q;
    assign b_col   = j_q;
    assign o_row   = i_q;
    assign o_col   = j_q;

endmodule
